seek_controller: RTL and testbench
==================================

# seek_controller

Host-side seek engine for the floppy step/direction interface. It converts a "go to track N" or "recalibrate" command into a timed sequence of direction-select and step pulses on the drive cable, and tracks the current head position. It is the initiator counterpart of the drive-side stepper driver. It samples the drive's track-0 sensor to home the head and reports completion or error to the host logic.

## Interface
- SETUP_CYCLES, 12: cycles `dir_sel` is held stable before the first step falling edge.
- PULSE_CYCLES, 12: width of each step low pulse, in cycles (≥1).
- STEP_CYCLES, 36000: falling-edge-to-falling-edge step period (≥ PULSE_CYCLES+1).
- SETTLE_CYCLES, 180000: head settle time after the last step period.
- MAX_TRACK, 79: highest legal track number.
- RECAL_MAX, 85: maximum step-out pulses during recalibrate before error.
- TRACK_W, 7: width of track fields.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- cmd_valid  in  1  command request
- cmd_ready  out  1  high only in IDLE; a command is accepted when cmd_valid && cmd_ready
- cmd_recal  in  1  1 = recalibrate, 0 = seek to cmd_track
- cmd_track  in  TRACK_W  seek target
- step_n  out  1  drive step line, active-low
- dir_sel  out  1  0 = step in (track+1), 1 = step out (track−1)
- tr0  in  1  drive track-0 sensor, asynchronous, high = at track 0
- cur_track  out  TRACK_W  current head position
- track_valid  out  1  cur_track is trustworthy (set by a successful recalibrate)
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle completion strobe
- err  out  1  valid only when done=1; 1 = command failed

## Operation
- Reset values: step_n=1, dir_sel=1, cur_track=0, track_valid=0, busy=0, done=0, err=0, cmd_ready=1. State is IDLE.
- tr0 passes through a 2-FF synchronizer (tr0_s). Sampled decisions use tr0_s.
- States: IDLE → SETUP → PULSE → GAP → (PULSE | SETTLE) → DONE → IDLE.
- Command checks at acceptance:
  - Seek with track_valid=0 → DONE with err=1. No steps are issued.
  - Seek with cmd_track > MAX_TRACK → DONE with err=1. No steps are issued.
  - Seek with cmd_track == cur_track → DONE with err=0. No steps and no settle.
  - Otherwise latch the target. dir_sel = (target < cur_track). Go to SETUP.
- Recalibrate:
  - dir_sel=1 and the step counter is cleared.
  - If tr0_s=1 at acceptance: cur_track=0, track_valid=1, go to DONE with err=0.
  - Otherwise track_valid=0 and go to SETUP.
- SETUP: hold for SETUP_CYCLES, then go to PULSE.
- PULSE: step_n=0 for PULSE_CYCLES.
  - Seek: on entry, cur_track ±1.
  - Recalibrate: on entry, step counter +1.
- GAP: step_n=1 for the remaining STEP_CYCLES−PULSE_CYCLES cycles. At the end:
  - Seek: cur_track == target → SETTLE; else → PULSE.
  - Recalibrate: tr0_s=1 → cur_track=0, track_valid=1, SETTLE.
  - Recalibrate: step counter == RECAL_MAX → DONE with err=1, track_valid=0.
  - Recalibrate: otherwise → PULSE.
- SETTLE: SETTLE_CYCLES, then DONE.
- DONE: done=1 for one cycle with err valid, then IDLE.
- dir_sel is never changed outside IDLE/acceptance. step_n never goes low in any state other than PULSE.
- cmd_valid while busy is ignored (not queued).
- Async reset mid-seek: step_n=1 immediately and track_valid=0 (position is lost).

## Timing
- Command accepted at edge k: busy=1 and dir_sel valid from k+1.
- First step_n fall at k+1+SETUP_CYCLES.
- Successive falls are exactly STEP_CYCLES apart. Each low phase is exactly PULSE_CYCLES.
- A seek of d tracks asserts done at cycle k+1+SETUP_CYCLES + d·STEP_CYCLES + SETTLE_CYCLES.
- Immediate-completion cases (error, same track, already at tr0): done at k+1, cmd_ready again at k+2.
- cur_track changes in the same cycle as the step_n falling edge.
- tr0 latency to decision: 2 cycles.

## Test plan
Override parameters for all scenarios: SETUP=1, PULSE=2, STEP=8, SETTLE=4, RECAL_MAX=85.
- Seek 5 after reset (track_valid=0) → done at k+1, err=1, step_n stays 1 throughout.
- Recalibrate with tr0 asserting after the 3rd pulse → exactly 3 pulses with dir_sel=1, each low 2 cycles and 8 cycles apart. Result: cur_track=0, track_valid=1, done err=0 after settle.
- From track 0, seek 3 → 3 pulses with dir_sel=0, cur_track sequence 1,2,3, done at k+1+1+24+4=k+30, err=0. Then seek 1 → 2 pulses with dir_sel=1, cur_track=1.
- Seek 80 (> MAX_TRACK) or seek equal to cur_track → done at k+1. err=1 for 80, err=0 for the equal case. No pulses in either case.
- Recalibrate with tr0 held 0 → exactly 85 pulses, then done with err=1 and track_valid=0.
- Assert rst during the 2nd PULSE of a seek → step_n=1 within the same cycle, track_valid=0, cur_track=0, cmd_ready=1 after reset release. A cmd_valid pulse during busy is ignored.

Source files
------------

// File: rtl/seek_controller.sv
`default_nettype none
// ============================================================================
//  Module      : seek_controller
//  Description : Host-side floppy seek engine. Turns seek / recalibrate
//                commands into timed dir_sel + step_n pulse trains, tracks
//                head position and homes on the drive track-0 sensor.
//  Revision    : 1.0 - initial release
// ============================================================================
module seek_controller #(
    parameter int SETUP_CYCLES  = 12,
    parameter int PULSE_CYCLES  = 12,
    parameter int STEP_CYCLES   = 36000,
    parameter int SETTLE_CYCLES = 180000,
    parameter int MAX_TRACK     = 79,
    parameter int RECAL_MAX     = 85,
    parameter int TRACK_W       = 7
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic               cmd_recal,
    input  logic [TRACK_W-1:0] cmd_track,
    output logic               step_n,
    output logic               dir_sel,
    input  logic               tr0,
    output logic [TRACK_W-1:0] cur_track,
    output logic               track_valid,
    output logic               busy,
    output logic               done,
    output logic               err
);

    localparam int c_gap_len = STEP_CYCLES - PULSE_CYCLES;
    localparam int c_max_a   = (SETUP_CYCLES > PULSE_CYCLES) ? SETUP_CYCLES : PULSE_CYCLES;
    localparam int c_max_b   = (c_gap_len > SETTLE_CYCLES) ? c_gap_len : SETTLE_CYCLES;
    localparam int c_max_len = (c_max_a > c_max_b) ? c_max_a : c_max_b;
    localparam int c_cnt_w   = $clog2(c_max_len + 1);
    localparam int c_rc_w    = $clog2(RECAL_MAX + 1);

    localparam logic [c_cnt_w-1:0] c_setup_last  = c_cnt_w'(SETUP_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_pulse_last  = c_cnt_w'(PULSE_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_gap_last    = c_cnt_w'(c_gap_len - 1);
    localparam logic [c_cnt_w-1:0] c_settle_last = c_cnt_w'(SETTLE_CYCLES - 1);
    localparam logic [c_rc_w-1:0]  c_recal_max   = c_rc_w'(RECAL_MAX);
    localparam logic [TRACK_W-1:0] c_max_track   = TRACK_W'(MAX_TRACK);
    localparam logic [TRACK_W-1:0] c_one         = TRACK_W'(1);

    localparam logic [2:0] c_st_idle   = 3'd0;
    localparam logic [2:0] c_st_setup  = 3'd1;
    localparam logic [2:0] c_st_pulse  = 3'd2;
    localparam logic [2:0] c_st_gap    = 3'd3;
    localparam logic [2:0] c_st_settle = 3'd4;
    localparam logic [2:0] c_st_done   = 3'd5;

    logic [2:0]         r_state;
    logic [2:0]         w_state_nxt;
    logic               w_last;
    logic [c_cnt_w-1:0] r_cnt;
    logic [c_rc_w-1:0]  r_rcnt;
    logic [1:0]         r_tr0_sync;
    logic               r_tr0_s;
    logic               r_recal;
    logic [TRACK_W-1:0] r_target;
    logic [TRACK_W-1:0] r_cur_track;
    logic               r_track_valid;
    logic               r_dir;
    logic               r_step_n;
    logic               r_err;
    logic               w_seek_bad;
    logic               w_enter_pulse;

    assign r_tr0_s     = r_tr0_sync[1];
    assign cmd_ready   = (r_state == c_st_idle);
    assign busy        = (r_state != c_st_idle);
    assign done        = (r_state == c_st_done);
    assign err         = done & r_err;
    assign step_n      = r_step_n;
    assign dir_sel     = r_dir;
    assign cur_track   = r_cur_track;
    assign track_valid = r_track_valid;

    assign w_seek_bad    = !r_track_valid || (cmd_track > c_max_track);
    assign w_enter_pulse = (w_state_nxt == c_st_pulse) && (r_state != c_st_pulse);

    // Two-flop synchronizer for the asynchronous track-0 sensor
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_tr0_sync <= 2'b00;
        else     r_tr0_sync <= {r_tr0_sync[0], tr0};
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= c_st_idle;
        else     r_state <= w_state_nxt;
    end

    // Next-state logic: per-state dwell timeout and seek/recal branch decisions
    always_comb begin
        w_state_nxt = r_state;
        w_last      = 1'b0;
        case (r_state)
            c_st_setup:  w_last = (r_cnt == c_setup_last);
            c_st_pulse:  w_last = (r_cnt == c_pulse_last);
            c_st_gap:    w_last = (r_cnt == c_gap_last);
            c_st_settle: w_last = (r_cnt == c_settle_last);
            default:     w_last = 1'b0;
        endcase
        case (r_state)
            c_st_idle: begin
                if (cmd_valid) begin
                    if (cmd_recal)
                        w_state_nxt = r_tr0_s ? c_st_done : c_st_setup;
                    else if (w_seek_bad || (cmd_track == r_cur_track))
                        w_state_nxt = c_st_done;
                    else
                        w_state_nxt = c_st_setup;
                end
            end
            c_st_setup:  if (w_last) w_state_nxt = c_st_pulse;
            c_st_pulse:  if (w_last) w_state_nxt = c_st_gap;
            c_st_gap: begin
                if (w_last) begin
                    if (r_recal) begin
                        if (r_tr0_s)                    w_state_nxt = c_st_settle;
                        else if (r_rcnt == c_recal_max) w_state_nxt = c_st_done;
                        else                            w_state_nxt = c_st_pulse;
                    end else begin
                        w_state_nxt = (r_cur_track == r_target) ? c_st_settle : c_st_pulse;
                    end
                end
            end
            c_st_settle: if (w_last) w_state_nxt = c_st_done;
            c_st_done:   w_state_nxt = c_st_idle;
            default:     w_state_nxt = c_st_idle;
        endcase
    end

    // Dwell counter restarts on every state change
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_cnt <= '0;
        else if ((w_state_nxt != r_state) || (r_state == c_st_idle))
            r_cnt <= '0;
        else
            r_cnt <= r_cnt + c_cnt_w'(1);
    end

    // Step line is low exactly while in PULSE; registered so the cable sees no glitches
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_step_n <= 1'b1;
        else     r_step_n <= (w_state_nxt != c_st_pulse);
    end

    // Command latch, head position, recal step count and completion status
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_recal       <= 1'b0;
            r_target      <= '0;
            r_cur_track   <= '0;
            r_track_valid <= 1'b0;
            r_dir         <= 1'b1;
            r_rcnt        <= '0;
            r_err         <= 1'b0;
        end else begin
            if ((r_state == c_st_idle) && cmd_valid) begin
                r_recal <= cmd_recal;
                r_err   <= 1'b0;
                if (cmd_recal) begin
                    r_dir  <= 1'b1;
                    r_rcnt <= '0;
                    if (r_tr0_s) begin
                        r_cur_track   <= '0;
                        r_track_valid <= 1'b1;
                    end else begin
                        r_track_valid <= 1'b0;
                    end
                end else begin
                    r_target <= cmd_track;
                    if (w_seek_bad)
                        r_err <= 1'b1;
                    else if (cmd_track != r_cur_track)
                        r_dir <= (cmd_track < r_cur_track);
                end
            end
            // Position moves on the same edge that drops step_n
            if (w_enter_pulse) begin
                if (r_recal)    r_rcnt      <= r_rcnt + c_rc_w'(1);
                else if (r_dir) r_cur_track <= r_cur_track - c_one;
                else            r_cur_track <= r_cur_track + c_one;
            end
            if ((r_state == c_st_gap) && w_last && r_recal) begin
                if (r_tr0_s) begin
                    r_cur_track   <= '0;
                    r_track_valid <= 1'b1;
                end else if (r_rcnt == c_recal_max) begin
                    r_track_valid <= 1'b0;
                    r_err         <= 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seek_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seek_controller
//  Description : Self-checking bench for seek_controller (directed table,
//                randomized commands against a behavioural model, reset case)
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seek_controller;

    localparam int SET  = 1;
    localparam int PUL  = 2;
    localparam int STP  = 8;
    localparam int SETL = 4;
    localparam int MAXT = 79;
    localparam int RMAX = 85;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_recal;
    logic [6:0] cmd_track;
    logic       step_n;
    logic       dir_sel;
    logic       tr0;
    logic [6:0] cur_track;
    logic       track_valid;
    logic       busy;
    logic       done;
    logic       err;

    int n_checks = 0;
    int n_fail   = 0;
    int m_cur    = 0;
    bit m_valid  = 1'b0;

    typedef struct {
        bit recal;
        int track;
        int tr0_after;   // 0: sensor already high, n>0: rises after n-th pulse, <0: never
        int start;
        int exp_pulses;
        bit exp_dir;
        int exp_done;    // cycles after the accepting edge
        bit exp_err;
        int exp_cur;
        bit exp_valid;
    } vec_t;

    seek_controller #(
        .SETUP_CYCLES (SET),
        .PULSE_CYCLES (PUL),
        .STEP_CYCLES  (STP),
        .SETTLE_CYCLES(SETL),
        .MAX_TRACK    (MAXT),
        .RECAL_MAX    (RMAX),
        .TRACK_W      (7)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_recal  (cmd_recal),
        .cmd_track  (cmd_track),
        .step_n     (step_n),
        .dir_sel    (dir_sel),
        .tr0        (tr0),
        .cur_track  (cur_track),
        .track_valid(track_valid),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Behavioural model: predicts the whole outcome of one command
    task automatic model(input bit recal, input int track, input int tr0_after, output vec_t v);
        int d;
        v.recal = recal; v.track = track; v.tr0_after = tr0_after; v.start = m_cur;
        v.exp_pulses = 0; v.exp_dir = 1'b1; v.exp_done = 1; v.exp_err = 1'b0;
        if (recal) begin
            if (tr0_after == 0) begin
                m_cur = 0; m_valid = 1'b1;
            end else if (tr0_after > 0) begin
                v.exp_pulses = tr0_after;
                v.exp_done   = 1 + SET + tr0_after * STP + SETL;
                m_cur = 0; m_valid = 1'b1;
            end else begin
                v.exp_pulses = RMAX;
                v.exp_done   = 1 + SET + RMAX * STP;
                v.exp_err    = 1'b1;
                m_valid      = 1'b0;
            end
        end else if (!m_valid || track > MAXT) begin
            v.exp_err = 1'b1;
        end else if (track != m_cur) begin
            d = (track > m_cur) ? track - m_cur : m_cur - track;
            v.exp_pulses = d;
            v.exp_dir    = (track < m_cur);
            v.exp_done   = 1 + SET + d * STP + SETL;
            m_cur        = track;
        end
        v.exp_cur   = m_cur;
        v.exp_valid = m_valid;
    endtask

    // Issue one command and check the pulse train, timing and final status
    task automatic apply(input vec_t v, input string tag);
        int  falls     = 0;
        int  last_fall = 0;
        int  low_len   = 0;
        int  done_t    = -1;
        bit  done_err  = 1'b0;
        bit  prev_sn   = 1'b1;
        int  exp_trk;
        @(negedge clk);
        tr0 = (v.tr0_after == 0);
        repeat (3) @(negedge clk);
        chk({tag, " ready_before"}, cmd_ready, 1);
        cmd_recal = v.recal;
        cmd_track = 7'(v.track);
        cmd_valid = 1'b1;
        for (int j = 1; j <= v.exp_done + 20; j++) begin
            @(negedge clk);
            if (j == 1) begin
                cmd_valid = 1'b0;
                chk({tag, " busy_after_accept"}, busy, 1);
            end
            if (prev_sn && !step_n) begin
                falls++;
                if (falls == 1) chk({tag, " first_fall_time"}, j, 1 + SET);
                else            chk({tag, " fall_spacing"}, j - last_fall, STP);
                last_fall = j;
                chk({tag, " dir_at_fall"}, dir_sel, v.exp_dir);
                if (!v.recal) begin
                    exp_trk = v.exp_dir ? v.start - falls : v.start + falls;
                    chk({tag, " cur_at_fall"}, cur_track, exp_trk);
                end
                low_len = 0;
            end
            if (!step_n) low_len++;
            if (!prev_sn && step_n) begin
                chk({tag, " pulse_width"}, low_len, PUL);
                if (v.recal && falls == v.tr0_after) tr0 = 1'b1;
            end
            prev_sn = step_n;
            if (done) begin
                done_t   = j;
                done_err = err;
                break;
            end
        end
        chk({tag, " done_time"}, done_t, v.exp_done);
        chk({tag, " done_err"}, done_err, v.exp_err);
        chk({tag, " pulse_count"}, falls, v.exp_pulses);
        @(negedge clk);
        chk({tag, " done_one_cycle"}, done, 0);
        chk({tag, " ready_after"}, cmd_ready, 1);
        chk({tag, " idle_not_busy"}, busy, 0);
        chk({tag, " final_cur"}, cur_track, v.exp_cur);
        chk({tag, " final_valid"}, track_valid, v.exp_valid);
    endtask

    initial begin
        vec_t tbl[9];
        vec_t v;
        int   r;
        int   tgt;
        int   falls;
        int   last_fall;
        bit   prev_sn;
        bit   hit;
        bit   rdir;

        // recal, track, tr0_after, start, pulses, dir, done, err, cur, valid
        tbl[0] = '{1'b0,  5, -1, 0,  0, 1'b1,   1, 1'b1, 0, 1'b0};
        tbl[1] = '{1'b1,  0,  3, 0,  3, 1'b1,  30, 1'b0, 0, 1'b1};
        tbl[2] = '{1'b0,  3, -1, 0,  3, 1'b0,  30, 1'b0, 3, 1'b1};
        tbl[3] = '{1'b0,  1, -1, 3,  2, 1'b1,  22, 1'b0, 1, 1'b1};
        tbl[4] = '{1'b0, 80, -1, 1,  0, 1'b1,   1, 1'b1, 1, 1'b1};
        tbl[5] = '{1'b0,  1, -1, 1,  0, 1'b1,   1, 1'b0, 1, 1'b1};
        tbl[6] = '{1'b1,  0,  0, 1,  0, 1'b1,   1, 1'b0, 0, 1'b1};
        tbl[7] = '{1'b1,  0, -1, 0, 85, 1'b1, 682, 1'b1, 0, 1'b0};
        tbl[8] = '{1'b1,  0,  1, 0,  1, 1'b1,  14, 1'b0, 0, 1'b1};

        rst = 1'b1; cmd_valid = 1'b0; cmd_recal = 1'b0; cmd_track = '0; tr0 = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst step_n", step_n, 1);
        chk("rst dir_sel", dir_sel, 1);
        chk("rst cur_track", cur_track, 0);
        chk("rst track_valid", track_valid, 0);
        chk("rst busy", busy, 0);
        chk("rst done", done, 0);
        chk("rst err", err, 0);
        chk("rst cmd_ready", cmd_ready, 1);
        rst = 1'b0;

        for (int i = 0; i < 9; i++) apply(tbl[i], $sformatf("tbl%0d", i));
        m_cur   = tbl[8].exp_cur;
        m_valid = tbl[8].exp_valid;

        for (int i = 0; i < 24; i++) begin
            r = int'($urandom_range(0, 9));
            if (r < 2)      model(1'b1, 0, int'($urandom_range(0, 4)), v);
            else if (r < 3) model(1'b0, m_cur, -1, v);
            else            model(1'b0, int'($urandom_range(0, 90)), -1, v);
            apply(v, $sformatf("rnd%0d", i));
        end

        // Reset during the 2nd step pulse; a command offered while busy must be ignored
        tgt  = (m_cur < 70) ? m_cur + 5 : m_cur - 5;
        rdir = (tgt < m_cur);
        @(negedge clk);
        tr0 = 1'b0;
        repeat (3) @(negedge clk);
        cmd_recal = 1'b0; cmd_track = 7'(tgt); cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        falls = 0; last_fall = 0; prev_sn = 1'b1; hit = 1'b0;
        for (int j = 1; j <= 40; j++) begin
            if (j == 4) begin cmd_valid = 1'b1; cmd_recal = 1'b1; end
            if (j == 5) cmd_valid = 1'b0;
            if (prev_sn && !step_n) begin
                falls++;
                if (falls == 2) begin
                    chk("rstseq fall_spacing", j - last_fall, STP);
                    chk("rstseq dir", dir_sel, rdir);
                    chk("rstseq cur_at_fall2", cur_track, rdir ? m_cur - 2 : m_cur + 2);
                    hit = 1'b1;
                    break;
                end
                last_fall = j;
            end
            prev_sn = step_n;
            @(negedge clk);
        end
        chk("rstseq reached_pulse2", hit, 1);
        #1 rst = 1'b1;
        #1;
        chk("rstseq step_n_high", step_n, 1);
        chk("rstseq valid_lost", track_valid, 0);
        chk("rstseq cur_zero", cur_track, 0);
        chk("rstseq not_busy", busy, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rstseq ready_after", cmd_ready, 1);
        m_cur = 0; m_valid = 1'b0;
        model(1'b0, 5, -1, v);
        apply(v, "post_rst_seek");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
